// File: rtl/fibonacci_pkg.sv
// Shared types and defaults for the Fibonacci stream source.
package fibonacci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_IDX_W = 8;

endpackage

// File: rtl/fib_core.sv
// Term datapath: holds the current/next terms and a sticky flag marking that
// the next term no longer fits in WIDTH bits.
module fib_core
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] prev,
  output logic             cur_ovf
);

  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, prev} + {1'b0, cur};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= '0;
      cur     <= '0;
      cur_ovf <= 1'b0;
    end else if (load) begin
      prev    <= seed0;
      cur     <= seed1;
      cur_ovf <= 1'b0;
    end else if (adv) begin
      prev    <= cur;
      cur     <= sum[WIDTH-1:0];
      cur_ovf <= cur_ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/fibonacci_stream.sv
// Fibonacci-type term source with valid/ready output, term-count limit and
// overflow handling (stop or wrap).
module fibonacci_stream
  import fibonacci_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int WRAP_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] n_terms,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fibout,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_e           state, state_nxt;
  logic [IDX_W-1:0] cnt, term_lim;
  logic [WIDTH-1:0] prev;
  logic             cur_ovf;
  logic             load, accept, lim_hit, ovf_stop, adv, ovf_set;

  assign load     = enb & start;
  assign accept   = out_valid & out_ready & enb;
  assign lim_hit  = (term_lim != '0) && (cnt == term_lim - IDX_W'(1));
  assign ovf_stop = cur_ovf && (WRAP_MODE == 0);

  fib_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .adv     (adv),
    .seed0   (seed0),
    .seed1   (seed1),
    .prev    (prev),
    .cur_ovf (cur_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // start beats a same-cycle accept; count termination beats overflow.
  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = RUN;
    else if (accept && (lim_hit || ovf_stop))
      state_nxt = DONE;
  end

  always_comb begin
    out_valid = (state == RUN) & enb;
    busy      = (state == RUN);
    done      = (state == DONE);
    adv       = accept & ~load & ~lim_hit & ~ovf_stop;
    ovf_set   = accept & ~load & ~lim_hit & cur_ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      term_lim <= '0;
      ovf      <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      term_lim <= n_terms;
      ovf      <= 1'b0;
    end else begin
      if (adv)     cnt <= cnt + IDX_W'(1);
      if (ovf_set) ovf <= 1'b1;
    end
  end

  assign fibout = prev;
  assign idx    = cnt;

endmodule
